ahb_slave_mem: RTL

- AHB responder (slave) terminating the bus driven by the AXI-to-AHB bridge's AHB controller.
- Backs the bus with an internal 64-bit-wide memory.
- Supports single NONSEQ/SEQ transfers of 8–64 bits with little-endian byte lanes.
- Provides optional wait-state insertion and a two-cycle ERROR response for illegal accesses. Used as the bridge's verification target and as on-chip scratch RAM.

---
 rtl/ahb_slave_mem_if.sv | 24 ++
 rtl/ahb_slave_mem.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem_if.sv
// AHB bus bundle between one master and the ahb_slave_mem responder.
interface ahb_slave_mem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [63:0] hwdata;
  logic        hready;
  logic [63:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB responder backed by a 64-bit-wide memory, with two-cycle ERROR responses.
// Define AHB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states on every legal transfer.
module ahb_slave_mem #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  hclk,
  input  logic                  hreset,
  ahb_slave_mem_if.slave        bus,
  output logic [15:0]           err_count
);

  localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] MemBytes = 33'(MEM_DEPTH) << 3;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWait = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StErr1 = 3'd3;
  localparam logic [2:0] StErr2 = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic [7:0]      mask_q;
  logic            write_q;
  logic [63:0]     hrdata_q, hrdata_d;
  logic [15:0]     err_q;
  logic [63:0]     mem [MEM_DEPTH];

  logic            ready_state;
  logic            accept;
  logic            legal;
  logic            size_ok, align_ok, range_ok;
  logic [32:0]     offset;
  logic [IdxW-1:0] idx_new;
  logic [7:0]      mask_base, mask_new;
  logic            commit;
  logic [63:0]     rd_word;

`ifdef AHB_SLAVE_WAIT_EN
  logic [3:0]      wcnt_q, wcnt_d;
`else
  logic [3:0]      unused_wait_cfg;
  assign unused_wait_cfg = 4'(WAIT_CYCLES);
`endif

  logic unused_bus;
  assign unused_bus = ^{bus.hburst, bus.htrans[0]};

  // Address-phase decode; the 33-bit offset exposes addresses below the base as a borrow.
  assign offset   = {1'b0, bus.haddr} - {1'b0, ADDR_BASE};
  assign range_ok = ~offset[32] && (offset < MemBytes);
  assign idx_new  = offset[IdxW+2:3];

  always_comb begin
    size_ok   = 1'b1;
    align_ok  = 1'b1;
    mask_base = 8'h00;
    case (bus.hsize)
      3'd0: mask_base = 8'h01;
      3'd1: begin
        mask_base = 8'h03;
        align_ok  = ~bus.haddr[0];
      end
      3'd2: begin
        mask_base = 8'h0F;
        align_ok  = (bus.haddr[1:0] == 2'b00);
      end
      3'd3: begin
        mask_base = 8'hFF;
        align_ok  = (bus.haddr[2:0] == 3'b000);
      end
      default: begin
        size_ok  = 1'b0;
        align_ok = 1'b0;
      end
    endcase
  end

  assign mask_new    = mask_base << bus.haddr[2:0];
  assign legal       = size_ok & align_ok & range_ok;
  assign ready_state = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept      = ready_state & bus.hsel & bus.hready & bus.htrans[1];
  assign commit      = (state_q == StData) & write_q;

  // Read capture merges the write committing on this same edge so the read sees new data.
  always_comb begin
    rd_word = mem[idx_new];
    for (int b = 0; b < 8; b++) begin
      if (commit && (idx_q == idx_new) && mask_q[b]) begin
        rd_word[8*b +: 8] = bus.hwdata[8*b +: 8];
      end
      if (!mask_new[b]) begin
        rd_word[8*b +: 8] = 8'h00;
      end
    end
    hrdata_d = (accept && legal && !bus.hwrite) ? rd_word : hrdata_q;
  end

  always_comb begin
    state_d = state_q;
`ifdef AHB_SLAVE_WAIT_EN
    wcnt_d  = wcnt_q;
`endif
    if (accept) begin
      if (!legal) begin
        state_d = StErr1;
      end else begin
`ifdef AHB_SLAVE_WAIT_EN
        if (WAIT_CYCLES != 0) begin
          state_d = StWait;
          wcnt_d  = 4'(WAIT_CYCLES - 1);
        end else begin
          state_d = StData;
        end
`else
        state_d = StData;
`endif
      end
    end else begin
      case (state_q)
        StWait: begin
`ifdef AHB_SLAVE_WAIT_EN
          if (wcnt_q == 4'd0) begin
            state_d = StData;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
          end
`else
          state_d = StIdle;
`endif
        end
        StErr1:  state_d = StErr2;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      mask_q   <= '0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
      err_q    <= '0;
`ifdef AHB_SLAVE_WAIT_EN
      wcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hrdata_q <= hrdata_d;
`ifdef AHB_SLAVE_WAIT_EN
      wcnt_q   <= wcnt_d;
`endif
      if (accept) begin
        idx_q   <= idx_new;
        mask_q  <= mask_new;
        write_q <= bus.hwrite & legal;
      end
      if ((state_q == StErr2) && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
    end
  end

  // Memory has no reset; a write pending at reset is simply never committed.
  always_ff @(posedge hclk) begin
    if (!hreset && commit) begin
      for (int b = 0; b < 8; b++) begin
        if (mask_q[b]) begin
          mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.hreadyout = ready_state;
  assign bus.hresp     = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
  assign bus.hrdata    = hrdata_q;
  assign err_count     = err_q;

endmodule
